aes_controller_output: RTL and testbench

- Bus-independent AES controller output block; the transmit-side counterpart of the controller input block.
- Accepts 128-bit result blocks, each tagged with a last flag, from the AES core side and buffers them in an internal FIFO.
- Serializes each block into four 32-bit words on a valid/ready bus interface, applying the codebase's 128-bit byte-reversal before serialization.
- Asserts bus_tlast on the final word of a last-flagged block.

---
 rtl/aes_controller_output.sv | 147 ++++++++++++++
 tb/tb_aes_controller_output.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_controller_output.sv
// aes_controller_output: queues 128-bit AES result blocks and emits each as four byte-reversed 32-bit words.
// Latency: block written at cycle N is on the bus at N+2; words hold under backpressure, full FIFO refuses blocks.
// Optional macro AES_CONTROLLER_OUTPUT_STATS_EN adds stat_blk_cnt / stat_pkt_cnt handshake counters.
module aes_controller_output #(
    parameter int BUS_DATA_WIDTH  = 32,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int FIFO_DATA_WIDTH = 128
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       blk_tvalid,
    output logic                       blk_tready,
    input  logic [FIFO_DATA_WIDTH-1:0] blk_data,
    input  logic                       blk_tlast,
    output logic                       bus_tvalid,
    input  logic                       bus_tready,
    output logic [BUS_DATA_WIDTH-1:0]  bus_data,
    output logic                       bus_tlast,
`ifdef AES_CONTROLLER_OUTPUT_STATS_EN
    output logic [31:0]                stat_blk_cnt,
    output logic [31:0]                stat_pkt_cnt,
`endif
    output logic                       controller_out_idle
);
    localparam int DEPTH  = 1 << FIFO_ADDR_WIDTH;
    localparam int NBYTES = FIFO_DATA_WIDTH / 8;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [FIFO_DATA_WIDTH:0]         mem_q [DEPTH];
    logic [FIFO_ADDR_WIDTH:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                             fifo_empty, fifo_full, fifo_wr, fifo_rd;
    logic [FIFO_DATA_WIDTH:0]         rd_entry;
    logic [FIFO_DATA_WIDTH-1:0]       rd_rev;
    logic [3:0][BUS_DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                             last_q, last_d;
    logic [1:0]                       cnt_q, cnt_d;
    logic [0:0]                       state_q, state_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_ADDR_WIDTH-1:0] == rd_ptr_q[FIFO_ADDR_WIDTH-1:0])
                     && (wr_ptr_q[FIFO_ADDR_WIDTH] != rd_ptr_q[FIFO_ADDR_WIDTH]);
    assign blk_tready = !fifo_full;
    assign fifo_wr    = blk_tvalid && !fifo_full;
    assign rd_entry   = mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]];

    always_comb begin
        rd_rev = '0;
        for (int i = 0; i < NBYTES; i++) begin
            rd_rev[8*i +: 8] = rd_entry[8*(NBYTES-1-i) +: 8];
        end
    end

    assign bus_tvalid          = (state_q == ST_SEND);
    assign bus_data            = bus_tvalid ? hold_q[cnt_q] : '0;
    assign bus_tlast           = bus_tvalid && last_q && (cnt_q == 2'd3);
    assign controller_out_idle = fifo_empty && !bus_tvalid;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        fifo_rd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    hold_d  = rd_rev;
                    last_d  = rd_entry[FIFO_DATA_WIDTH];
                    cnt_d   = 2'd0;
                    state_d = ST_SEND;
                end
            end
            default: begin
                if (bus_tready) begin
                    if (cnt_q != 2'd3) begin
                        cnt_d = cnt_q + 2'd1;
                    end else if (!fifo_empty) begin
                        // Reload on the final word so back-to-back blocks leave no bubble.
                        fifo_rd = 1'b1;
                        hold_d  = rd_rev;
                        last_d  = rd_entry[FIFO_DATA_WIDTH];
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
        wr_ptr_d = wr_ptr_q + {{FIFO_ADDR_WIDTH{1'b0}}, fifo_wr};
        rd_ptr_d = rd_ptr_q + {{FIFO_ADDR_WIDTH{1'b0}}, fifo_rd};
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= {blk_tlast, blk_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            last_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef AES_CONTROLLER_OUTPUT_STATS_EN
    logic        bus_hs;
    logic [31:0] stat_blk_cnt_q, stat_blk_cnt_d, stat_pkt_cnt_q, stat_pkt_cnt_d;

    assign bus_hs = bus_tvalid && bus_tready;

    always_comb begin
        stat_blk_cnt_d = stat_blk_cnt_q + {31'd0, bus_hs && (cnt_q == 2'd3)};
        stat_pkt_cnt_d = stat_pkt_cnt_q + {31'd0, bus_hs && bus_tlast};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_blk_cnt_q <= '0;
            stat_pkt_cnt_q <= '0;
        end else begin
            stat_blk_cnt_q <= stat_blk_cnt_d;
            stat_pkt_cnt_q <= stat_pkt_cnt_d;
        end
    end

    assign stat_blk_cnt = stat_blk_cnt_q;
    assign stat_pkt_cnt = stat_pkt_cnt_q;
`else
    // Default build carries no statistics counters.
`endif
endmodule

// File: tb/tb_aes_controller_output.sv
// Directed + randomized bench for aes_controller_output with a word-queue reference model.
module tb_aes_controller_output;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         blk_tvalid = 1'b0;
    logic         blk_tready;
    logic [127:0] blk_data = '0;
    logic         blk_tlast = 1'b0;
    logic         bus_tvalid;
    logic         bus_tready = 1'b0;
    logic [31:0]  bus_data;
    logic         bus_tlast;
    logic         controller_out_idle;
`ifdef AES_CONTROLLER_OUTPUT_STATS_EN
    logic [31:0]  stat_blk_cnt;
    logic [31:0]  stat_pkt_cnt;
`endif

    aes_controller_output dut (
        .clk                 (clk),
        .reset               (reset),
        .blk_tvalid          (blk_tvalid),
        .blk_tready          (blk_tready),
        .blk_data            (blk_data),
        .blk_tlast           (blk_tlast),
        .bus_tvalid          (bus_tvalid),
        .bus_tready          (bus_tready),
        .bus_data            (bus_data),
        .bus_tlast           (bus_tlast),
`ifdef AES_CONTROLLER_OUTPUT_STATS_EN
        .stat_blk_cnt        (stat_blk_cnt),
        .stat_pkt_cnt        (stat_pkt_cnt),
`endif
        .controller_out_idle (controller_out_idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          words_seen = 0;
    int          tlast_seen = 0;
    int          blk_writes = 0;
    logic        last_blk_hs = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat = '0;
    logic        prev_last = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: output word k holds bytes 4k..4k+3 of the byte-reversed block, low byte first.
    task automatic model_push(input logic [127:0] data, input logic last);
        exp_t e;
        for (int w = 0; w < 4; w++) begin
            e.w = 32'd0;
            for (int b = 0; b < 4; b++) begin
                int src;
                src = 15 - (4 * w + b);
                e.w = e.w | (32'((data >> (8 * src)) & 128'hFF) << (8 * b));
            end
            e.l = last && (w == 3);
            exp_q.push_back(e);
        end
    endtask

    // Inputs change at posedge+1; sampling happens at posedge+3 before the next edge.
    task automatic tick();
        exp_t e;
        #2;
        last_blk_hs = 1'b0;
        if (!reset) begin
            if (prev_stall) begin
                chk("stall_vld", bus_tvalid, 1'b1);
                chk("stall_dat", bus_data, prev_dat);
                chk("stall_last", bus_tlast, prev_last);
            end
            if (bus_tvalid && bus_tready) begin
                chk("word_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("bus_dat", bus_data, e.w);
                    chk("bus_last", bus_tlast, e.l);
                end
                words_seen++;
                if (bus_tlast) tlast_seen++;
            end
            if (blk_tvalid && blk_tready) begin
                model_push(blk_data, blk_tlast);
                blk_writes++;
                last_blk_hs = 1'b1;
            end
        end
        prev_stall = !reset && bus_tvalid && !bus_tready;
        prev_dat   = bus_data;
        prev_last  = bus_tlast;
        @(posedge clk);
        #1;
    endtask

    task automatic send_blk(input logic [127:0] data, input logic last);
        int n;
        blk_data   = data;
        blk_tlast  = last;
        blk_tvalid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_blk_hs && n < 300);
        chk("send_accept", last_blk_hs, 1'b1);
        blk_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !controller_out_idle) && n < 500) begin
            tick();
            n++;
        end
        chk("drain_idle", controller_out_idle, 1'b1);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, t0, run, cnt;
        logic [3:0] pat;
        logic [127:0] d;

        #1;
        do_reset();
        chk("rst_tvalid", bus_tvalid, 1'b0);
        chk("rst_data", bus_data, 32'd0);
        chk("rst_tlast", bus_tlast, 1'b0);
        chk("rst_blk_tready", blk_tready, 1'b1);
        chk("rst_idle", controller_out_idle, 1'b1);

        // Single known block: latency N+2 and exact word order.
        bus_tready = 1'b1;
        w0 = words_seen;
        t0 = tlast_seen;
        blk_data   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        blk_tlast  = 1'b1;
        blk_tvalid = 1'b1;
        tick();
        blk_tvalid = 1'b0;
        chk("lat_n1_tvalid", bus_tvalid, 1'b0);
        tick();
        chk("lat_n2_tvalid", bus_tvalid, 1'b1);
        chk("lat_n2_word0", bus_data, 32'h33221100);
        for (int i = 0; i < 4; i++) tick();
        chk("single_words", words_seen - w0, 4);
        chk("single_tlast", tlast_seen - t0, 1);
        chk("single_idle", controller_out_idle, 1'b1);

        // Three queued blocks stream as 12 contiguous words.
        bus_tready = 1'b0;
        t0 = tlast_seen;
        for (int b = 0; b < 3; b++) send_blk(rand_blk(), b == 2);
        tick();
        bus_tready = 1'b1;
        run = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus_tvalid) run++;
            tick();
        end
        chk("b2b_contig", run, 12);
        chk("b2b_tlast", tlast_seen - t0, 1);
        drain();

        // Stall pattern 1,0,0,1 across random blocks.
        for (int rep = 0; rep < 3; rep++) begin
            pat = 4'b1001;
            w0  = words_seen;
            send_blk(rand_blk(), 1'($urandom_range(0, 1)));
            cnt = 0;
            while ((exp_q.size() != 0 || !controller_out_idle) && cnt < 200) begin
                bus_tready = pat[cnt % 4];
                tick();
                cnt++;
            end
            chk("stall_words", words_seen - w0, 4);
            bus_tready = 1'b1;
        end
        drain();

        // Fill: stage holds one block, FIFO takes exactly 16 more.
        bus_tready = 1'b0;
        send_blk(rand_blk(), 1'b0);
        tick();
        tick();
        cnt = 0;
        blk_data   = rand_blk();
        blk_tlast  = 1'($urandom_range(0, 1));
        blk_tvalid = 1'b1;
        for (int i = 0; i < 40 && cnt < 16; i++) begin
            tick();
            if (last_blk_hs) begin
                cnt++;
                blk_data  = rand_blk();
                blk_tlast = 1'($urandom_range(0, 1));
            end
        end
        chk("fill_writes", cnt, 16);
        chk("fill_tready_low", blk_tready, 1'b0);
        w0 = blk_writes;
        for (int i = 0; i < 3; i++) tick();
        chk("fill_refused", blk_writes - w0, 0);
        bus_tready = 1'b1;
        d = blk_data;
        send_blk(d, blk_tlast);
        drain();

        // Reset mid-block with blocks queued behind it.
        bus_tready = 1'b0;
        for (int b = 0; b < 4; b++) send_blk(rand_blk(), b == 3);
        tick();
        tick();
        bus_tready = 1'b1;
        tick();
        tick();
        bus_tready = 1'b0;
        reset = 1'b1;
        tick();
        chk("mid_rst_tvalid", bus_tvalid, 1'b0);
        chk("mid_rst_idle", controller_out_idle, 1'b1);
        chk("mid_rst_blk_tready", blk_tready, 1'b1);
        exp_q.delete();
        reset = 1'b0;
        bus_tready = 1'b1;
        w0 = words_seen;
        for (int i = 0; i < 10; i++) tick();
        chk("post_rst_no_words", words_seen - w0, 0);
        chk("post_rst_idle", controller_out_idle, 1'b1);

        // Random traffic with random backpressure.
        for (int b = 0; b < 8; b++) begin
            bus_tready = 1'($urandom_range(0, 1));
            send_blk(rand_blk(), 1'($urandom_range(0, 1)));
        end
        bus_tready = 1'b1;
        drain();

`ifdef AES_CONTROLLER_OUTPUT_STATS_EN
        do_reset();
        chk("stat_blk_rst", stat_blk_cnt, 32'd0);
        chk("stat_pkt_rst", stat_pkt_cnt, 32'd0);
        bus_tready = 1'b1;
        for (int b = 0; b < 5; b++) send_blk(rand_blk(), (b == 1) || (b == 4));
        drain();
        chk("stat_blk", stat_blk_cnt, 32'd5);
        chk("stat_pkt", stat_pkt_cnt, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
